// File: rtl/controle_caixa_dagua.sv
// Irrigation water tank controller.
// Synchronises and debounces the H/M/L level sensors, classifies the tank
// level, drives the inlet valve with hysteresis and a fill timeout, gates the
// irrigation pump against the level and latches faults until acknowledged.
module controle_caixa_dagua #(
  parameter int DEB_CYCLES   = 8,
  parameter int DEB_W        = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int TO_W         = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       REQ_REGA,
  input  logic       ACK_ERRO,
  output logic       VE,
  output logic       BOMBA,
  output logic       AL,
  output logic       ERRO,
  output logic [1:0] NIVEL,
  output logic [1:0] ESTADO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENCHE = 2'd1,
    CHEIO = 2'd2,
    FALHA = 2'd3
  } state_t;

  // The debounce counter never holds DEB_CYCLES-1: the vector is accepted on
  // the edge where the count would reach it, so the count stops one short.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FILL_TIMEOUT - 1);

  localparam logic [2:0] CODE_CRITICO = 3'b000;
  localparam logic [2:0] CODE_BAIXO   = 3'b001;
  localparam logic [2:0] CODE_MEDIO   = 3'b011;
  localparam logic [2:0] CODE_ALTO    = 3'b111;

  // Input path registers
  logic [2:0]       sync_a;
  logic [2:0]       sync_y;
  logic [2:0]       y_prev;
  logic [2:0]       s_deb;
  logic [DEB_W-1:0] deb_cnt;

  // Level classification of the debounced vector
  logic             s_valid;
  logic             s_full;
  logic             s_critico;
  logic             s_needs_fill;
  logic [1:0]       level_code;

  // Control state
  state_t           state;
  state_t           state_next;
  logic [TO_W-1:0]  to_cnt;
  logic             fill_timeout;

  // Two-flop synchroniser bringing the raw sensors into the clock domain
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_a <= '0;
      sync_y <= '0;
    end else begin
      sync_a <= {H, M, L};
      sync_y <= sync_a;
    end
  end

  // Debounce: accept the synchronised vector once it has been stable and
  // different from the accepted one for DEB_CYCLES consecutive cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_prev  <= '0;
      s_deb   <= '0;
      deb_cnt <= '0;
    end else begin
      y_prev <= sync_y;
      if ((sync_y == s_deb) || (sync_y != y_prev)) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        s_deb   <= sync_y;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Classify the debounced vector; a wet sensor above a dry one is a fault
  always_comb begin
    s_valid      = ~((s_deb[1] & ~s_deb[0]) | (s_deb[2] & ~s_deb[1]));
    s_full       = (s_deb == CODE_ALTO);
    s_critico    = (s_deb == CODE_CRITICO);
    s_needs_fill = ~s_deb[1];
    unique case (s_deb)
      CODE_BAIXO: level_code = 2'd1;
      CODE_MEDIO: level_code = 2'd2;
      CODE_ALTO:  level_code = 2'd3;
      default:    level_code = 2'd0;
    endcase
  end

  assign fill_timeout = (to_cnt == TO_LAST);

  // Level indicator follows valid codes and freezes on invalid ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      NIVEL <= 2'd0;
    end else if (s_valid) begin
      NIVEL <= level_code;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: invalid sensors first, then timeout, then level; medio never
  // starts a fill, which gives the valve its hysteresis band
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!s_valid)          state_next = FALHA;
        else if (s_full)       state_next = CHEIO;
        else if (s_needs_fill) state_next = ENCHE;
      end
      ENCHE: begin
        if (!s_valid)          state_next = FALHA;
        else if (s_full)       state_next = CHEIO;
        else if (fill_timeout) state_next = FALHA;
      end
      CHEIO: begin
        if (!s_valid)          state_next = FALHA;
        else if (s_needs_fill) state_next = ENCHE;
      end
      FALHA: begin
        if (ACK_ERRO && s_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill timer restarts on every entry to ENCHE and counts while filling
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt <= '0;
    end else if ((state_next == ENCHE) && (state != ENCHE)) begin
      to_cnt <= '0;
    end else if (state == ENCHE) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Pump and alarm are registered and look ahead at the next state so the
  // pump drops on the same edge that enters FALHA
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BOMBA <= 1'b0;
      AL    <= 1'b0;
    end else begin
      BOMBA <= REQ_REGA & s_deb[0] & (state_next != FALHA);
      AL    <= (state_next == FALHA) | s_critico;
    end
  end

  assign VE     = (state == ENCHE);
  assign ERRO   = (state == FALHA);
  assign ESTADO = state;

endmodule

// File: tb/tb_controle_caixa_dagua.sv
// Self-checking bench for controle_caixa_dagua: directed sequences followed by
// random sensor levels, checked by a scoreboard fed from a behavioural model.
module tb_controle_caixa_dagua;

  localparam int DEB = 8;
  localparam int FT  = 50;
  localparam int HIST_LEN = DEB + 2;

  localparam int ST_IDLE  = 0;
  localparam int ST_ENCHE = 1;
  localparam int ST_CHEIO = 2;
  localparam int ST_FALHA = 3;

  logic       clk;
  logic       rst_n;
  logic       h, m, l;
  logic       req_rega;
  logic       ack_erro;
  logic       ve, bomba, al, erro;
  logic [1:0] nivel, estado;

  typedef struct {
    logic       ve;
    logic       bomba;
    logic       al;
    logic       erro;
    logic [1:0] nivel;
    logic [1:0] estado;
  } exp_t;

  exp_t       sb_q[$];
  int         total;
  int         bad;
  int         cycle_no;

  // Reference model state
  logic [2:0] raw_hist[$];
  logic [2:0] m_s;
  int         m_state;
  int         m_fill;
  logic [1:0] m_nivel;

  controle_caixa_dagua #(
    .DEB_CYCLES  (DEB),
    .DEB_W       (4),
    .FILL_TIMEOUT(FT),
    .TO_W        (16)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .H       (h),
    .M       (m),
    .L       (l),
    .REQ_REGA(req_rega),
    .ACK_ERRO(ack_erro),
    .VE      (ve),
    .BOMBA   (bomba),
    .AL      (al),
    .ERRO    (erro),
    .NIVEL   (nivel),
    .ESTADO  (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isValid(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
  endfunction

  task automatic modelReset();
    m_s     = 3'b000;
    m_state = ST_IDLE;
    m_fill  = 0;
    m_nivel = 2'd0;
    raw_hist.delete();
    for (int i = 0; i < HIST_LEN; i++) raw_hist.push_back(3'b000);
  endtask

  // One clock edge of the tank controller described by its rules: a sensor
  // vector is accepted once it has been seen unchanged for DEB cycles after
  // two cycles of synchroniser delay; NIVEL is the number of wet sensors.
  task automatic modelStep(input logic [2:0] lvl, input logic req, input logic ack, input logic rst);
    exp_t       e;
    int         nst;
    bit         inval;
    bit         stable;
    logic [2:0] cand;
    int         n;
    if (!rst) begin
      modelReset();
      e.ve = 0; e.bomba = 0; e.al = 0; e.erro = 0; e.nivel = 0; e.estado = 0;
      sb_q.push_back(e);
      return;
    end
    inval = !isValid(m_s);
    nst   = m_state;
    case (m_state)
      ST_IDLE: begin
        if (inval) nst = ST_FALHA;
        else if (m_s == 3'b111) nst = ST_CHEIO;
        else if (m_s == 3'b000 || m_s == 3'b001) nst = ST_ENCHE;
      end
      ST_ENCHE: begin
        if (inval) nst = ST_FALHA;
        else if (m_s == 3'b111) nst = ST_CHEIO;
        else if (m_fill == FT - 1) nst = ST_FALHA;
      end
      ST_CHEIO: begin
        if (inval) nst = ST_FALHA;
        else if (m_s == 3'b000 || m_s == 3'b001) nst = ST_ENCHE;
      end
      default: begin
        if (ack && !inval) nst = ST_IDLE;
      end
    endcase
    e.estado = 2'(nst);
    e.ve     = (nst == ST_ENCHE);
    e.erro   = (nst == ST_FALHA);
    e.bomba  = req & m_s[0] & (nst != ST_FALHA);
    e.al     = (nst == ST_FALHA) || (m_s == 3'b000);
    if (!inval) m_nivel = 2'($countones(m_s));
    e.nivel  = m_nivel;
    sb_q.push_back(e);
    // cycles already spent in the current fill
    if (m_state == ST_ENCHE) m_fill++;
    else m_fill = 0;
    // debounce window: raw samples taken 2..DEB+1 edges ago
    n      = raw_hist.size();
    cand   = raw_hist[n - 2];
    stable = 1;
    for (int k = 2; k <= DEB + 1; k++) if (raw_hist[n - k] != cand) stable = 0;
    if (stable && cand != m_s) m_s = cand;
    raw_hist.push_back(lvl);
    void'(raw_hist.pop_front());
    m_state = nst;
  endtask

  task automatic applyStimulus(input logic [2:0] lvl, input logic req, input logic ack,
                               input logic rst, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      rst_n       = rst;
      {h, m, l}   = lvl;
      req_rega    = req;
      ack_erro    = ack;
      modelStep(lvl, req, ack, rst);
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: one expected entry per clock edge, compared mid-cycle
  initial begin
    exp_t e;
    cycle_no = 0;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (ve !== e.ve || bomba !== e.bomba || al !== e.al || erro !== e.erro ||
            nivel !== e.nivel || estado !== e.estado) begin
          bad++;
          $display("[TB] FAIL scoreboard cycle %0d: got ve=%b bomba=%b al=%b erro=%b nivel=%0d estado=%0d, expected ve=%b bomba=%b al=%b erro=%b nivel=%0d estado=%0d",
                   cycle_no, ve, bomba, al, erro, nivel, estado,
                   e.ve, e.bomba, e.al, e.erro, e.nivel, e.estado);
        end
      end
    end
  end

  initial begin
    logic [2:0] good_codes[4];
    logic [2:0] bad_codes[4];
    logic [2:0] lvl;
    int         dur;
    total = 0;
    bad   = 0;
    good_codes[0] = 3'b000; good_codes[1] = 3'b001;
    good_codes[2] = 3'b011; good_codes[3] = 3'b111;
    bad_codes[0]  = 3'b010; bad_codes[1]  = 3'b100;
    bad_codes[2]  = 3'b101; bad_codes[3]  = 3'b110;
    rst_n = 1'b0; h = 0; m = 0; l = 0; req_rega = 0; ack_erro = 0;
    modelReset();

    $display("[TB] reset with empty tank");
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("reset_estado", estado, 0);
    checkOutput("reset_al", al, 0);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 3);
    checkOutput("empty_fills", estado, ST_ENCHE);
    checkOutput("empty_no_pump", bomba, 0);

    $display("[TB] filling L, M, H");
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 15);
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 15);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 15);
    checkOutput("full_estado", estado, ST_CHEIO);
    checkOutput("full_ve", ve, 0);
    checkOutput("full_nivel", nivel, 3);
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 15);
    checkOutput("medio_no_refill", ve, 0);
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 15);
    checkOutput("baixo_refills", estado, ST_ENCHE);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 15);

    $display("[TB] short glitch then long dip");
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 5);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 15);
    checkOutput("glitch_ignored", nivel, 3);
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 12);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 15);

    $display("[TB] invalid sensor pattern");
    applyStimulus(3'b110, 1'b1, 1'b0, 1'b1, 15);
    checkOutput("invalid_estado", estado, ST_FALHA);
    checkOutput("invalid_nivel_hold", nivel, 3);
    checkOutput("invalid_pump_off", bomba, 0);
    applyStimulus(3'b110, 1'b0, 1'b1, 1'b1, 3);
    checkOutput("ack_ignored_invalid", erro, 1);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 12);
    applyStimulus(3'b111, 1'b0, 1'b1, 1'b1, 1);
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 3);
    checkOutput("ack_recovers", estado, ST_CHEIO);

    $display("[TB] fill timeout");
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 70);
    checkOutput("timeout_estado", estado, ST_FALHA);
    checkOutput("timeout_ve", ve, 0);

    $display("[TB] pump gating and async reset");
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b1, 12);
    applyStimulus(3'b011, 1'b1, 1'b1, 1'b1, 1);
    applyStimulus(3'b011, 1'b1, 1'b0, 1'b1, 5);
    checkOutput("pump_on_medio", bomba, 1);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 20);
    checkOutput("critico_fills", ve, 1);
    checkOutput("critico_pump_off", bomba, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    modelStep({h, m, l}, req_rega, ack_erro, 1'b0);
    #1;
    checkOutput("async_ve", ve, 0);
    checkOutput("async_al", al, 0);
    checkOutput("async_estado", estado, 0);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 2);

    $display("[TB] random levels");
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 7) == 0) lvl = bad_codes[$urandom_range(0, 3)];
      else lvl = good_codes[$urandom_range(0, 3)];
      dur = $urandom_range(1, 30);
      for (int c = 0; c < dur; c++) begin
        applyStimulus(lvl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 299) != 0), 1);
      end
    end

    repeat (2) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
